// File: rtl/probe_capture.sv
// In-fabric capture core: samples a probe bus into a circular buffer around a
// masked level/rising trigger and serves the frozen capture by logical index.
module probe_capture #(
   parameter int DATA_W = 24,
   parameter int TRIG_W = 7,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              arm,
   input  logic              abort,
   input  logic              trig_mode,
   input  logic [TRIG_W-1:0] trig_mask,
   input  logic [TRIG_W-1:0] trig_value,
   input  logic [ADDR_W-1:0] pretrig,
   input  logic [TRIG_W-1:0] trig_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              triggered,
   output logic              done
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] MAX_P = AW'(DEPTH - 1);

   typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;

   state_t              state, next_state;
   logic [TRIG_W-1:0]   mask_q, value_q;
   logic                mode_q;
   logic [AW-1:0]       p_q, p_in;
   logic [AW-1:0]       wr_ptr, trig_ptr, post_cnt, rd_phys;
   logic                match, match_prev, hit, we, rd_ok, rd_pend;
   logic                unused_hi;
   logic [DATA_W-1:0]   mem [DEPTH];

   // The pretrig port may be wider than the buffer index, so clamp before use.
   always_comb begin
      p_in = pretrig[AW-1:0];
      if ({{(32-ADDR_W){1'b0}}, pretrig} > 32'(DEPTH - 1))
         p_in = MAX_P;
   end

   assign unused_hi = ^{pretrig, rd_addr};
   assign match     = ((trig_i ^ value_q) & mask_q) == '0;
   assign hit       = mode_q ? (match & ~match_prev) : match;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (abort)
         next_state = IDLE;
      else if (arm)
         next_state = (p_in != '0) ? PRE : WAIT;
      else begin
         case (state)
            PRE:     if (wr_ptr == p_q - 1'b1) next_state = WAIT;
            WAIT:    if (hit) next_state = (p_q == MAX_P) ? DONE : POST;
            POST:    if (post_cnt == AW'(1)) next_state = DONE;
            default: next_state = state;
         endcase
      end
   end

   // A restart or abort edge never writes and never starts a read.
   always_comb begin
      busy  = (state == PRE) || (state == WAIT) || (state == POST);
      done  = (state == DONE);
      we    = busy & ~arm & ~abort;
      rd_ok = rd_en & done & ~arm & ~abort;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mask_q     <= '0;
         value_q    <= '0;
         mode_q     <= 1'b0;
         p_q        <= '0;
         wr_ptr     <= '0;
         trig_ptr   <= '0;
         post_cnt   <= '0;
         triggered  <= 1'b0;
         match_prev <= 1'b0;
      end else begin
         match_prev <= match;
         if (abort) begin
            triggered <= 1'b0;
         end else if (arm) begin
            mask_q    <= trig_mask;
            value_q   <= trig_value;
            mode_q    <= trig_mode;
            p_q       <= p_in;
            wr_ptr    <= '0;
            triggered <= 1'b0;
         end else if (we) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (state == WAIT && hit) begin
               trig_ptr  <= wr_ptr;
               triggered <= 1'b1;
               post_cnt  <= MAX_P - p_q;
            end
            if (state == POST)
               post_cnt <= post_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (we)
         mem[wr_ptr] <= data_i;
   end

   // Two-stage read: registered address, then registered RAM output.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rd_pend  <= 1'b0;
         rd_phys  <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_pend  <= rd_ok;
         rd_valid <= rd_pend;
         if (rd_ok)
            rd_phys <= trig_ptr - p_q + rd_addr[AW-1:0];
         if (rd_pend)
            rd_data <= mem[rd_phys];
      end
   end

endmodule

// File: tb/tb_probe_capture.sv
// Randomised self-checking bench for probe_capture (DEPTH=16, ADDR_W=5);
// expected buffers come from a sample-window model of each capture.
module tb_probe_capture;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        arm, abort, trig_mode;
   logic [6:0]  trig_mask, trig_value, trig_i;
   logic [4:0]  pretrig, rd_addr;
   logic [23:0] data_i, rd_data;
   logic        rd_en, rd_valid, busy, triggered, done;

   int          checks = 0;
   int          passes = 0;
   logic [6:0]  oldMask = '0;
   logic [6:0]  oldValue = '0;
   int          expK, expP;
   logic [23:0] dataSeq [128];
   logic [6:0]  trigSeq [128];

   probe_capture #(.DATA_W(24), .TRIG_W(7), .DEPTH(16), .ADDR_W(5)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .arm(arm), .abort(abort),
      .trig_mode(trig_mode), .trig_mask(trig_mask), .trig_value(trig_value),
      .pretrig(pretrig), .trig_i(trig_i), .data_i(data_i), .rd_en(rd_en),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
      .triggered(triggered), .done(done)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed === expected)
         passes++;
      else
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // Builds a stimulus pattern, predicts the trigger cycle from the match
   // rules, then drives the capture checking triggered/done every cycle.
   task automatic applyStimulus(input logic [6:0] mask, input logic [6:0] value,
                                input logic mode, input logic [4:0] pre,
                                input int patt, input int stopAfter,
                                input logic rdDuring);
      int          p, k, doneIdx;
      logic [6:0]  trigPre;
      logic        mp, m;
      logic [23:0] heldRd;
      logic [31:0] r;
      p = (pre > 5'd15) ? 15 : int'(pre);
      trigPre = 7'($urandom);
      for (int c = 0; c < 128; c++) begin
         r = $urandom;
         dataSeq[c] = r[23:0];
         r = $urandom;
         trigSeq[c] = r[6:0];
         case (patt)
            0: begin
               trigSeq[c] = 7'(c + 1);
               dataSeq[c] = 24'(c + 1);
            end
            1: begin
               if (c == 40) trigSeq[c] = value ^ mask;
               if (c > 40)  trigSeq[c] = value;
            end
            2: trigSeq[c] = {r[6:1], (c >= 8 && c < 10) ? 1'b0 : 1'b1};
            3: trigSeq[c] = (c < 40) ? 7'h00 : 7'h7F;
            default: ;
         endcase
      end
      if (patt == 0 || patt == 3) trigPre = 7'h00;
      if (patt == 2) trigPre = 7'h01;

      mp = ((trigPre ^ oldValue) & oldMask) == 7'h00;
      k = -1;
      for (int c = 0; c < 128; c++) begin
         m = ((trigSeq[c] ^ value) & mask) == 7'h00;
         if (k < 0 && c >= p && (mode ? (m && !mp) : m)) k = c;
         mp = m;
      end
      doneIdx = (k < 0) ? 1000 : k + 15 - p;
      expK = k;
      expP = p;

      @(negedge sys_clk);
      arm = 1'b1; trig_mask = mask; trig_value = value; trig_mode = mode;
      pretrig = pre; trig_i = trigPre; data_i = 24'($urandom); rd_en = rdDuring;
      @(negedge sys_clk);
      arm = 1'b0;
      oldMask = mask;
      oldValue = value;
      checkOutput("busy_after_arm", 32'(busy), 32'd1);
      checkOutput("triggered_after_arm", 32'(triggered), 32'd0);
      checkOutput("done_after_arm", 32'(done), 32'd0);
      heldRd = rd_data;
      if (rdDuring) checkOutput("rd_valid_at_arm", 32'(rd_valid), 32'd0);

      for (int c = 0; c < 128; c++) begin
         if (stopAfter >= 0 && c >= stopAfter) break;
         trig_i = trigSeq[c];
         data_i = dataSeq[c];
         @(negedge sys_clk);
         checkOutput($sformatf("triggered_c%0d", c), 32'(triggered),
                     32'(k >= 0 && c >= k));
         checkOutput($sformatf("done_c%0d", c), 32'(done), 32'(c >= doneIdx));
         if (rdDuring) begin
            checkOutput("rd_valid_busy", 32'(rd_valid), 32'd0);
            checkOutput("rd_data_held", 32'(rd_data), 32'(heldRd));
         end
         if (c == doneIdx) begin
            checkOutput("busy_at_done", 32'(busy), 32'd0);
            break;
         end
      end
      rd_en = 1'b0;
   endtask

   // Back-to-back reads of all 16 logical indices against the model window.
   task automatic checkOutputBuffer();
      for (int j = 0; j <= 16; j++) begin
         rd_en = (j < 16);
         rd_addr = 5'(j);
         @(negedge sys_clk);
         if (j == 0)
            checkOutput("rd_valid_latency", 32'(rd_valid), 32'd0);
         else begin
            checkOutput("rd_valid", 32'(rd_valid), 32'd1);
            checkOutput($sformatf("rd_data_idx%0d", j - 1), 32'(rd_data),
                        32'(dataSeq[expK - expP + j - 1]));
         end
      end
      rd_en = 1'b0;
      @(negedge sys_clk);
      checkOutput("rd_valid_end", 32'(rd_valid), 32'd0);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_triggered"}, 32'(triggered), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
   endtask

   initial begin
      sys_rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig_mode = 1'b0;
      trig_mask = '0; trig_value = '0; trig_i = '0; pretrig = '0;
      rd_addr = '0; data_i = '0; rd_en = 1'b0;
      repeat (3) @(negedge sys_clk);
      checkIdle("reset");
      checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
      sys_rst_n = 1'b1;

      $display("[TB] counting trigger, P=4");
      applyStimulus(7'h7F, 7'h05, 1'b0, 5'd4, 0, -1, 1'b0);
      checkOutputBuffer();

      $display("[TB] rising trigger with reads attempted while busy");
      applyStimulus(7'h01, 7'h01, 1'b1, 5'd2, 2, -1, 1'b1);
      checkOutputBuffer();

      $display("[TB] P=0 random level trigger");
      applyStimulus(7'($urandom) | 7'h01, 7'($urandom), 1'b0, 5'd0, 1, -1, 1'b0);
      checkOutputBuffer();

      $display("[TB] pretrig=31 clamps to 15");
      applyStimulus(7'($urandom) | 7'h01, 7'($urandom), 1'b0, 5'd31, 1, -1, 1'b0);
      checkOutputBuffer();

      $display("[TB] long wait with wrap");
      applyStimulus(7'h7F, 7'h7F, 1'b0, 5'd4, 3, -1, 1'b0);
      checkOutputBuffer();

      $display("[TB] all-zero mask level triggers at once");
      applyStimulus(7'h00, 7'($urandom), 1'b0, 5'd3, 1, -1, 1'b0);
      checkOutputBuffer();

      $display("[TB] arm mid-post restarts");
      applyStimulus(7'h7F, 7'h05, 1'b0, 5'd4, 0, 8, 1'b0);
      applyStimulus(7'($urandom) | 7'h02, 7'($urandom), 1'b1, 5'd6, 1, -1, 1'b0);
      checkOutputBuffer();

      $display("[TB] abort together with arm mid-wait");
      applyStimulus(7'h7F, 7'h7F, 1'b0, 5'd4, 3, 20, 1'b0);
      @(negedge sys_clk);
      abort = 1'b1; arm = 1'b1;
      @(negedge sys_clk);
      abort = 1'b0; arm = 1'b0;
      checkIdle("abort");
      @(negedge sys_clk);
      checkIdle("abort_hold");
      applyStimulus(7'($urandom) | 7'h01, 7'($urandom), 1'b0, 5'd9, 1, -1, 1'b0);
      checkOutputBuffer();

      $display("[TB] zero mask rising never triggers");
      applyStimulus(7'h00, 7'($urandom), 1'b1, 5'd2, 1, 30, 1'b0);
      @(negedge sys_clk);
      abort = 1'b1;
      @(negedge sys_clk);
      abort = 1'b0;
      checkIdle("abort2");

      $display("[TB] async reset mid-pre");
      applyStimulus(7'h7F, 7'($urandom), 1'b0, 5'd10, 1, 3, 1'b0);
      #2 sys_rst_n = 1'b0;
      #1 checkIdle("async_reset");
      checkOutput("async_reset_rd_valid", 32'(rd_valid), 32'd0);
      oldMask = '0;
      oldValue = '0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      applyStimulus(7'($urandom) | 7'h04, 7'($urandom), 1'b1, 5'd5, 1, -1, 1'b0);
      checkOutputBuffer();

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
